// File: rtl/masked_hpc3_pipe_mul_pkg.sv
// masked_hpc3_pipe_mul_pkg: share-pair indexing and GF(2^w) multiply helpers
package masked_hpc3_pipe_mul_pkg;
  localparam int MAX_W = 8;
  function automatic int num_quad(input int n);
    return n * (n - 1) / 2;
  endfunction
  function automatic int qindex(input int i, input int j, input int n);
    int lo, hi;
    lo = i < j ? i : j;
    hi = i < j ? j : i;
    return lo * n - lo * (lo + 1) / 2 + hi - lo - 1;
  endfunction
  function automatic logic [MAX_W-1:0] low_poly(input int w);
    return w == 8 ? MAX_W'('h1B) : w == 5 ? MAX_W'('h05) : w == 1 ? MAX_W'(0) : MAX_W'('h03);
  endfunction
  function automatic logic [MAX_W-1:0] gf_mul(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] y, input int w);
    logic [MAX_W:0] sh, red;
    logic [MAX_W-1:0] acc;
    acc = '0;
    sh = {1'b0, x};
    red = {1'b0, low_poly(w)} | ((MAX_W+1)'(1) << w);
    for (int k = 0; k < MAX_W; k++)
      if (k < w) begin
        acc ^= y[k] ? sh[MAX_W-1:0] : '0;
        sh = sh << 1;
        sh = sh[w] ? sh ^ red : sh;
      end
    return acc & ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction
endpackage

// File: rtl/masked_hpc3_pipe_mul_lane.sv
// masked_hpc3_lane: one HPC3 multiplier lane, stage registers loaded only on en
module masked_hpc3_lane
  import masked_hpc3_pipe_mul_pkg::*;
#(
  parameter int NS = 2,
  parameter int W  = 1
) (
  input  logic                         in_clock,
  input  logic                         in_reset,
  input  logic                         en,
  input  logic [NS*W-1:0]              a,
  input  logic [NS*W-1:0]              b,
  input  logic [num_quad(NS)*W-1:0]    r,
  input  logic [num_quad(NS)*W-1:0]    p,
  output logic [NS*W-1:0]              c
);
  logic [W-1:0] ra [NS];
  logic [W-1:0] rb [NS];
  logic [W-1:0] v  [NS][NS-1];
  logic [W-1:0] w  [NS][NS-1];
  // stage registers: cleared by reset, written only when a transfer fires
  always_ff @(posedge in_clock)
    if (!in_reset) begin
      for (int i = 0; i < NS; i++) begin
        ra[i] <= '0;
        rb[i] <= '0;
        for (int j = 0; j < NS - 1; j++) begin
          v[i][j] <= '0;
          w[i][j] <= '0;
        end
      end
    end else if (en) begin
      for (int i = 0; i < NS; i++) begin
        ra[i] <= a[i*W +: W];
        rb[i] <= b[i*W +: W];
        for (int j = 0; j < NS; j++)
          if (j != i) begin
            v[i][j < i ? j : j - 1] <= b[j*W +: W] ^ r[qindex(i, j, NS)*W +: W];
            w[i][j < i ? j : j - 1] <= W'(gf_mul(MAX_W'(a[i*W +: W]), MAX_W'(r[qindex(i, j, NS)*W +: W]), W))
                                       ^ p[qindex(i, j, NS)*W +: W];
          end
      end
    end
  // output shares recombine only registered values, so no glitch reaches stale inputs
  always_comb begin
    logic [W-1:0] bs, ws;
    c = '0;
    for (int i = 0; i < NS; i++) begin
      bs = rb[i];
      ws = '0;
      for (int j = 0; j < NS - 1; j++) begin
        bs ^= v[i][j];
        ws ^= w[i][j];
      end
      c[i*W +: W] = W'(gf_mul(MAX_W'(ra[i]), MAX_W'(bs), W)) ^ ws;
    end
  end
endmodule

// File: rtl/masked_hpc3_pipe_mul.sv
// masked_hpc3_pipe_mul: multi-lane handshaked HPC3 masked GF multiplier, latency 1
module masked_hpc3_pipe_mul
  import masked_hpc3_pipe_mul_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 1,
  parameter int NUM_LANES  = 1,
  parameter int ZERO_IDLE  = 1
) (
  input  logic                                             in_clock,
  input  logic                                             in_reset,
  input  logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0]        in_a,
  input  logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0]        in_b,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [NUM_LANES*num_quad(NUM_SHARES)*BIT_WIDTH-1:0] in_r,
  input  logic [NUM_LANES*num_quad(NUM_SHARES)*BIT_WIDTH-1:0] in_p,
  input  logic                                             in_rand_valid,
  output logic                                             in_rand_ready,
  output logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0]        out_c,
  output logic                                             out_valid,
  input  logic                                             out_ready
);
  localparam int SW = NUM_SHARES * BIT_WIDTH;
  localparam int QW = num_quad(NUM_SHARES) * BIT_WIDTH;
  logic fire;
  logic [NUM_LANES*SW-1:0] c_raw;
  assign in_ready      = !out_valid || out_ready;
  assign fire          = in_valid && in_rand_valid && in_ready;
  assign in_rand_ready = fire;
  assign out_c         = (ZERO_IDLE != 0 && !out_valid) ? '0 : c_raw;
  // single-entry occupancy: load on fire, empty when drained without a refill
  always_ff @(posedge in_clock)
    if (!in_reset) out_valid <= 1'b0;
    else if (fire) out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    masked_hpc3_lane #(.NS(NUM_SHARES), .W(BIT_WIDTH)) u_lane (
      .in_clock (in_clock),
      .in_reset (in_reset),
      .en       (fire),
      .a        (in_a[l*SW +: SW]),
      .b        (in_b[l*SW +: SW]),
      .r        (in_r[l*QW +: QW]),
      .p        (in_p[l*QW +: QW]),
      .c        (c_raw[l*SW +: SW])
    );
  end
endmodule

// File: tb/tb_masked_hpc3_pipe_mul.sv
// tb_masked_hpc3_pipe_mul: directed handshake checks plus a randomised GF(2^8) stream
module tb_masked_hpc3_pipe_mul;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [1:0] s_a, s_b, s_c;
  logic s_r, s_p, s_valid, s_rv, s_ordy, s_in_ready, s_rand_ready, s_out_valid;
  logic [95:0] b_a, b_b, b_r, b_p, b_c;
  logic b_valid, b_rv, b_ordy, b_in_ready, b_rand_ready, b_out_valid;
  int n_cmp = 0, n_bad = 0;
  masked_hpc3_pipe_mul #(.NUM_SHARES(2), .BIT_WIDTH(1), .NUM_LANES(1), .ZERO_IDLE(1)) dut (
    .in_clock(clk), .in_reset(rst_n), .in_a(s_a), .in_b(s_b), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_r(s_r), .in_p(s_p), .in_rand_valid(s_rv), .in_rand_ready(s_rand_ready),
    .out_c(s_c), .out_valid(s_out_valid), .out_ready(s_ordy));
  masked_hpc3_pipe_mul #(.NUM_SHARES(3), .BIT_WIDTH(8), .NUM_LANES(4), .ZERO_IDLE(1)) dut_big (
    .in_clock(clk), .in_reset(rst_n), .in_a(b_a), .in_b(b_b), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_r(b_r), .in_p(b_p), .in_rand_valid(b_rv), .in_rand_ready(b_rand_ready),
    .out_c(b_c), .out_valid(b_out_valid), .out_ready(b_ordy));
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic hi;
    acc = 8'h00;
    repeat (8) begin
      if (y[0]) acc ^= x;
      hi = x[7];
      x = x << 1;
      if (hi) x ^= 8'h1B;
      y = y >> 1;
    end
    return acc;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    s_a = 2'($urandom); s_b = 2'($urandom); s_r = 1'($urandom); s_p = 1'($urandom);
    s_valid = 1'b1; s_rv = 1'b1; s_ordy = 1'($urandom);
    b_valid = 1'b1; b_rv = 1'b1; b_ordy = 1'b0;
    b_a = {3{32'($urandom)}}; b_b = {3{32'($urandom)}}; b_r = {3{32'($urandom)}}; b_p = {3{32'($urandom)}};
    tick; tick;
    n_cmp++; if (s_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", s_out_valid); end
    n_cmp++; if (s_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", s_in_ready); end
    n_cmp++; if (s_c !== 2'b00) begin n_bad++; $display("FAIL reset_out_c: got %b want 00", s_c); end
    n_cmp++; if (b_out_valid !== 1'b0 || b_c !== '0) begin n_bad++; $display("FAIL reset_big: valid %b c %h want 0/0", b_out_valid, b_c); end
    rst_n = 1'b1; s_valid = 1'b0; s_rv = 1'b0; s_ordy = 1'b1; b_valid = 1'b0; b_rv = 1'b0; b_ordy = 1'b1;
    tick;
  endtask
  task automatic test_single;
    s_a = 2'b01; s_b = 2'b10; s_r = 1'b1; s_p = 1'b0; s_valid = 1'b1; s_rv = 1'b1; s_ordy = 1'b1;
    #1;
    n_cmp++; if (s_rand_ready !== 1'b1) begin n_bad++; $display("FAIL single_rand_ready: got %b want 1", s_rand_ready); end
    tick;
    s_valid = 1'b0; s_rv = 1'b0;
    #1;
    n_cmp++; if (s_out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", s_out_valid); end
    n_cmp++; if (s_c !== 2'b01) begin n_bad++; $display("FAIL single_shares: got %b want 01", s_c); end
    n_cmp++; if (s_rand_ready !== 1'b0) begin n_bad++; $display("FAIL single_rand_once: got %b want 0", s_rand_ready); end
    tick;
    n_cmp++; if (s_out_valid !== 1'b0 || s_c !== 2'b00) begin n_bad++; $display("FAIL single_drain: valid %b c %b want 0/00", s_out_valid, s_c); end
  endtask
  task automatic test_starvation;
    s_a = 2'b10; s_b = 2'b01; s_r = 1'b0; s_p = 1'b1; s_valid = 1'b1; s_rv = 1'b0; s_ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (s_rand_ready !== 1'b0 || s_out_valid !== 1'b0) begin n_bad++; $display("FAIL starve_%0d: rand_ready %b valid %b want 0/0", k, s_rand_ready, s_out_valid); end
      tick;
    end
    s_rv = 1'b1;
    #1;
    n_cmp++; if (s_rand_ready !== 1'b1) begin n_bad++; $display("FAIL starve_release: got %b want 1", s_rand_ready); end
    tick;
    s_valid = 1'b0; s_rv = 1'b0;
    #1;
    n_cmp++; if (s_out_valid !== 1'b1 || s_c !== 2'b01) begin n_bad++; $display("FAIL starve_result: valid %b c %b want 1/01", s_out_valid, s_c); end
    tick;
  endtask
  task automatic test_backpressure;
    s_a = 2'b11; s_b = 2'b11; s_r = 1'b1; s_p = 1'b1; s_valid = 1'b1; s_rv = 1'b1; s_ordy = 1'b0;
    tick;
    s_a = 2'b01; s_b = 2'b10; s_r = 1'b0; s_p = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (s_in_ready !== 1'b0 || s_rand_ready !== 1'b0 || s_out_valid !== 1'b1 || s_c !== 2'b11) begin
        n_bad++; $display("FAIL stall_%0d: in_ready %b rand_ready %b valid %b c %b want 0/0/1/11", k, s_in_ready, s_rand_ready, s_out_valid, s_c);
      end
      tick;
    end
    s_ordy = 1'b1;
    #1;
    n_cmp++; if (s_in_ready !== 1'b1 || s_rand_ready !== 1'b1) begin n_bad++; $display("FAIL release: in_ready %b rand_ready %b want 1/1", s_in_ready, s_rand_ready); end
    tick;
    s_valid = 1'b0; s_rv = 1'b0;
    #1;
    n_cmp++; if (s_out_valid !== 1'b1 || s_c !== 2'b01) begin n_bad++; $display("FAIL back_to_back: valid %b c %b want 1/01", s_out_valid, s_c); end
    tick;
    n_cmp++; if (s_out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", s_out_valid); end
  endtask
  task automatic test_reset_mid_stall;
    s_a = 2'b01; s_b = 2'b10; s_r = 1'b1; s_p = 1'b0; s_valid = 1'b1; s_rv = 1'b1; s_ordy = 1'b0;
    tick;
    s_valid = 1'b0; s_rv = 1'b0;
    n_cmp++; if (s_out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_load: got %b want 1", s_out_valid); end
    rst_n = 1'b0;
    tick;
    n_cmp++; if (s_out_valid !== 1'b0 || s_c !== 2'b00) begin n_bad++; $display("FAIL mid_reset: valid %b c %b want 0/00", s_out_valid, s_c); end
    rst_n = 1'b1; s_ordy = 1'b1;
    tick;
    n_cmp++; if (s_out_valid !== 1'b0 || s_c !== 2'b00) begin n_bad++; $display("FAIL no_replay: valid %b c %b want 0/00", s_out_valid, s_c); end
  endtask
  task automatic test_stream;
    logic [31:0] expq[$];
    logic [31:0] exp_w, obs;
    logic [7:0] x, y, s0, s1;
    int fired = 0, got = 0, cyc = 0;
    while ((fired < 1000 || expq.size() != 0) && cyc < 20000) begin
      b_valid = fired < 1000 && $urandom_range(0, 9) < 7;
      b_rv = $urandom_range(0, 9) < 7;
      b_ordy = $urandom_range(0, 9) < 6;
      for (int l = 0; l < 4; l++) begin
        x = 8'($urandom); y = 8'($urandom);
        s0 = 8'($urandom); s1 = 8'($urandom);
        b_a[l*24 +: 24] = {x ^ s0 ^ s1, s1, s0};
        s0 = 8'($urandom); s1 = 8'($urandom);
        b_b[l*24 +: 24] = {y ^ s0 ^ s1, s1, s0};
        exp_w[l*8 +: 8] = gmul(x, y);
      end
      b_r = {32'($urandom), 32'($urandom), 32'($urandom)};
      b_p = {32'($urandom), 32'($urandom), 32'($urandom)};
      #1;
      if (b_out_valid && b_ordy) begin
        for (int l = 0; l < 4; l++) obs[l*8 +: 8] = b_c[l*24 +: 8] ^ b_c[l*24+8 +: 8] ^ b_c[l*24+16 +: 8];
        n_cmp++;
        if (expq.size() == 0) begin n_bad++; $display("FAIL stream_extra: got %h with nothing outstanding", obs); end
        else begin
          if (obs !== expq[0]) begin n_bad++; $display("FAIL stream_op%0d: got %h want %h", got, obs, expq[0]); end
          void'(expq.pop_front());
        end
        got++;
      end
      if (b_valid && b_rv && b_in_ready) begin expq.push_back(exp_w); fired++; end
      tick;
      cyc++;
    end
    b_valid = 1'b0; b_rv = 1'b0;
    n_cmp++; if (fired != 1000 || got != 1000) begin n_bad++; $display("FAIL stream_count: fired %0d got %0d want 1000/1000", fired, got); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_starvation;
    test_backpressure;
    test_reset_mid_stall;
    test_stream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
